// File: rtl/bm_memory_fifo_ctrl_if.sv
// Push/pop handshake bundle for bm_memory_fifo_ctrl.
//   push_valid / push_ready / push_data : upstream word into the FIFO
//   pop_valid  / pop_ready  / pop_data  : head word out of the FIFO
// The controller uses the slave modport; the producer/consumer side
// (or a testbench) uses the master modport.
interface bm_memory_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;

    modport master (
        output push_valid,
        output push_data,
        output pop_ready,
        input  push_ready,
        input  pop_valid,
        input  pop_data
    );

    modport slave (
        input  push_valid,
        input  push_data,
        input  pop_ready,
        output push_ready,
        output pop_valid,
        output pop_data
    );
endinterface

// File: rtl/bm_memory_fifo_ctrl.sv
// FIFO controller wrapping a DEPTH-word registered-read memory.
// Words are written into the memory at wr_ptr, fetched back at rd_ptr
// (read data arrives one cycle after the address is sampled) and landed
// in a 2-entry skid buffer so the pop side can sustain one word per cycle.
//
// Ports:
//   clock           : single clock, all state on posedge
//   reset           : synchronous, active-high
//   fifo (slave)    : push/pop valid-ready handshake
//   mem_we          : memory write enable (= push accepted this cycle)
//   mem_address_in  : memory write address (write pointer)
//   mem_value_in    : memory write data (= push_data)
//   mem_address_out : memory read address (read pointer)
//   mem_value_out   : registered memory read data
//   level           : words held = memory count + in-flight fetch + skid count
module bm_memory_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bm_memory_fifo_ctrl_if.slave  fifo,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address_in,
    output logic [DATA_WIDTH-1:0] mem_value_in,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    input  logic [DATA_WIDTH-1:0] mem_value_out,
    output logic [2:0]            level
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      mem_cnt_r;
    logic                  fetch_pending_r;
    logic [1:0]            out_cnt_r;
    logic [DATA_WIDTH-1:0] out0_r;
    logic [DATA_WIDTH-1:0] out1_r;

    logic                  push_ready_s;
    logic                  push_fire_s;
    logic                  pop_valid_s;
    logic                  pop_fire_s;
    logic                  issue_s;
    logic [1:0]            skid_after_s;
    logic [1:0]            land_slot_s;
    logic [CNT_W-1:0]      mem_cnt_nxt_s;
    logic [DATA_WIDTH-1:0] out0_nxt_s;
    logic [DATA_WIDTH-1:0] out1_nxt_s;
    logic [2:0]            level_sum_s;

    // Handshake qualification, fetch decision and counter arithmetic.
    always_comb begin
        push_ready_s = !reset && (mem_cnt_r != MEM_FULL);
        push_fire_s  = fifo.push_valid && push_ready_s;
        pop_valid_s  = !reset && (out_cnt_r != 2'd0);
        pop_fire_s   = pop_valid_s && fifo.pop_ready;
        // Skid occupancy after this edge: a pending fetch always lands,
        // a pop always leaves. Cannot underflow since a pop needs out_cnt >= 1.
        skid_after_s = out_cnt_r + {1'b0, fetch_pending_r} - {1'b0, pop_fire_s};
        // Only issue a read if the landing slot will exist next cycle, so the
        // skid buffer can never be overrun by an in-flight word.
        issue_s      = (mem_cnt_r != {CNT_W{1'b0}}) && (skid_after_s <= 2'd1);
        // A landing word goes to the first free slot seen after any pop.
        land_slot_s  = out_cnt_r - {1'b0, pop_fire_s};
        mem_cnt_nxt_s = mem_cnt_r + {{(CNT_W-1){1'b0}}, push_fire_s}
                                  - {{(CNT_W-1){1'b0}}, issue_s};
        level_sum_s  = 3'(mem_cnt_r) + 3'(fetch_pending_r) + 3'(out_cnt_r);
    end

    // Skid buffer next values: pop shifts out1 into out0, then the fetch lands.
    always_comb begin
        out0_nxt_s = pop_fire_s ? out1_r : out0_r;
        out1_nxt_s = out1_r;
        case ({fetch_pending_r, land_slot_s})
            3'b100:  out0_nxt_s = mem_value_out;
            3'b101:  out1_nxt_s = mem_value_out;
            default: out1_nxt_s = out1_r;
        endcase
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r        <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r        <= {ADDR_WIDTH{1'b0}};
            mem_cnt_r       <= {CNT_W{1'b0}};
            fetch_pending_r <= 1'b0;
            out_cnt_r       <= 2'd0;
            out0_r          <= {DATA_WIDTH{1'b0}};
            out1_r          <= {DATA_WIDTH{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            fetch_pending_r <= issue_s;
            mem_cnt_r       <= mem_cnt_nxt_s;
            out_cnt_r       <= skid_after_s;
            out0_r          <= out0_nxt_s;
            out1_r          <= out1_nxt_s;
        end
    end

    assign fifo.push_ready = push_ready_s;
    assign fifo.pop_valid  = pop_valid_s;
    assign fifo.pop_data   = reset ? {DATA_WIDTH{1'b0}} : out0_r;

    assign mem_we          = push_fire_s;
    assign mem_address_in  = wr_ptr_r;
    assign mem_value_in    = fifo.push_data;
    assign mem_address_out = rd_ptr_r;
    assign level           = reset ? 3'd0 : level_sum_s;
endmodule

// File: tb/tb_bm_memory_fifo_ctrl.sv
// Self-checking bench for bm_memory_fifo_ctrl: a behavioural memory, a
// queue-based reference model compared every cycle, and directed scenarios
// with literal expectations.
module tb_bm_memory_fifo_ctrl;
    logic       clock;
    logic       reset;
    logic       mem_we;
    logic [1:0] mem_address_in;
    logic [7:0] mem_value_in;
    logic [1:0] mem_address_out;
    logic [7:0] mem_value_out;
    logic [2:0] level;

    int tests_run = 0;
    int tests_failed = 0;

    bm_memory_fifo_ctrl_if #(.DATA_WIDTH(8)) ifc ();

    bm_memory_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .fifo            (ifc.slave),
        .mem_we          (mem_we),
        .mem_address_in  (mem_address_in),
        .mem_value_in    (mem_value_in),
        .mem_address_out (mem_address_out),
        .mem_value_out   (mem_value_out),
        .level           (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 4 x 8 registered-read memory the controller wraps
    logic [7:0] mem_array [4];
    initial begin
        for (int i = 0; i < 4; i++) mem_array[i] = 8'h00;
        mem_value_out = 8'h00;
    end
    always @(posedge clock) begin
        if (mem_we) mem_array[mem_address_in] <= mem_value_in;
        mem_value_out <= mem_array[mem_address_out];
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in memory, one word in flight, skid contents.
    byte unsigned m_mem_q[$];
    byte unsigned m_out_q[$];
    bit           m_pend;
    byte unsigned m_pend_word;
    int           m_wr_cnt;
    int           m_rd_cnt;

    initial begin
        m_pend = 1'b0; m_pend_word = 8'h00; m_wr_cnt = 0; m_rd_cnt = 0;
    end

    // Compare process: inputs change only at posedge+2, so the negedge sees
    // stable inputs and settled outputs for the coming edge.
    always @(negedge clock) begin
        bit pf, popf, iss;
        int exp_level;
        if (reset) begin
            check("rst_push_ready", int'(ifc.push_ready), 0);
            check("rst_mem_we", int'(mem_we), 0);
            check("rst_pop_valid", int'(ifc.pop_valid), 0);
            check("rst_pop_data", int'(ifc.pop_data), 0);
            check("rst_level", int'(level), 0);
            m_mem_q.delete(); m_out_q.delete();
            m_pend = 1'b0; m_wr_cnt = 0; m_rd_cnt = 0;
        end else begin
            pf   = ifc.push_valid && (m_mem_q.size() != 4);
            popf = ifc.pop_ready && (m_out_q.size() != 0);
            iss  = (m_mem_q.size() != 0) &&
                   ((m_out_q.size() + int'(m_pend) - int'(popf)) <= 1);
            exp_level = m_mem_q.size() + int'(m_pend) + m_out_q.size();
            check("push_ready", int'(ifc.push_ready), int'(m_mem_q.size() != 4));
            check("mem_we", int'(mem_we), int'(pf));
            check("mem_address_in", int'(mem_address_in), m_wr_cnt % 4);
            if (mem_we) check("mem_value_in", int'(mem_value_in), int'(ifc.push_data));
            check("mem_address_out", int'(mem_address_out), m_rd_cnt % 4);
            check("pop_valid", int'(ifc.pop_valid), int'(m_out_q.size() != 0));
            if (m_out_q.size() != 0) check("pop_data", int'(ifc.pop_data), int'(m_out_q[0]));
            check("level", int'(level), exp_level);
            check("skid_invariant",
                  int'((int'(dut.out_cnt_r) + int'(dut.fetch_pending_r)) <= 2), 1);
            if (popf) void'(m_out_q.pop_front());
            if (m_pend) m_out_q.push_back(m_pend_word);
            if (iss) begin
                m_pend_word = m_mem_q.pop_front();
                m_pend = 1'b1;
                m_rd_cnt++;
            end else begin
                m_pend = 1'b0;
            end
            if (pf) begin
                m_mem_q.push_back(ifc.push_data);
                m_wr_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, n, acc_cnt, first_pop, last_pop, cyc, got;
        bit acc, prev_stall;
        byte unsigned prev_data, a0;
        byte unsigned exp_q[$];

        reset = 1'b1;
        ifc.push_valid = 1'b0; ifc.push_data = 8'h00; ifc.pop_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // 1: single push, 3-cycle latency to pop_valid
        ifc.push_valid = 1'b1; ifc.push_data = 8'hA5;
        @(negedge clock);
        check("t1_we", int'(mem_we), 1);
        check("t1_waddr", int'(mem_address_in), 0);
        tick();
        ifc.push_valid = 1'b0;
        tick();
        @(negedge clock);
        check("t1_not_yet_valid", int'(ifc.pop_valid), 0);
        tick();
        @(negedge clock);
        check("t1_valid", int'(ifc.pop_valid), 1);
        check("t1_data", int'(ifc.pop_data), 8'hA5);
        check("t1_level", int'(level), 1);
        tick();
        ifc.pop_ready = 1'b1;
        tick();
        ifc.pop_ready = 1'b0;

        // 2: fill to level 6 with pops stalled, then drain
        idx = 1; acc_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            ifc.push_valid = 1'b1; ifc.push_data = 8'(idx);
            @(negedge clock);
            acc = ifc.push_ready;
            tick();
            if (acc) begin
                acc_cnt++;
                if (idx < 7) idx++;
            end
        end
        ifc.push_valid = 1'b0;
        @(negedge clock);
        check("t2_accepted", acc_cnt, 6);
        check("t2_level_full", int'(level), 6);
        check("t2_push_ready_full", int'(ifc.push_ready), 0);
        tick();
        ifc.pop_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ifc.pop_valid) begin
                check("t2_pop_data", int'(ifc.pop_data), n + 1);
                n++;
            end
            tick();
        end
        @(negedge clock);
        check("t2_pop_count", n, 6);
        check("t2_empty", int'(ifc.pop_valid), 0);
        tick();

        // 3: streaming 20 words, one pop per cycle after fill
        ifc.pop_ready = 1'b1;
        idx = 0; n = 0; first_pop = -1; last_pop = -1;
        for (int c = 0; c < 50; c++) begin
            ifc.push_valid = (idx < 20);
            ifc.push_data  = 8'(8'h10 + idx);
            @(negedge clock);
            acc = ifc.push_valid && ifc.push_ready;
            if (ifc.pop_valid) begin
                check("t3_pop_data", int'(ifc.pop_data), 8'h10 + n);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                n++;
            end
            tick();
            if (acc) idx++;
        end
        ifc.push_valid = 1'b0;
        check("t3_pop_count", n, 20);
        check("t3_first_pop_cycle", first_pop, 3);
        check("t3_back_to_back", last_pop - first_pop, 19);

        // 4: random pop stalls, 50 random words
        idx = 0; got = 0; prev_stall = 1'b0; prev_data = 8'h00;
        for (cyc = 0; cyc < 600 && got < 50; cyc++) begin
            ifc.push_valid = (idx < 50);
            if (!acc || cyc == 0) ifc.push_data = 8'($urandom_range(0, 255));
            ifc.pop_ready = (idx >= 50) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            @(negedge clock);
            acc = ifc.push_valid && ifc.push_ready;
            if (acc) exp_q.push_back(ifc.push_data);
            if (prev_stall) check("t4_stall_stable", int'(ifc.pop_data), int'(prev_data));
            if (ifc.pop_valid && ifc.pop_ready) begin
                if (exp_q.size() != 0) check("t4_order", int'(ifc.pop_data), int'(exp_q.pop_front()));
                else check("t4_spurious_pop", 1, 0);
                got++;
            end
            prev_stall = ifc.pop_valid && !ifc.pop_ready;
            prev_data  = ifc.pop_data;
            tick();
            if (acc) begin
                idx++;
                ifc.push_data = 8'($urandom_range(0, 255));
            end
        end
        ifc.push_valid = 1'b0;
        check("t4_words_popped", got, 50);
        repeat (3) tick();

        // 5: reset mid-stream discards contents
        ifc.pop_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ifc.push_valid = 1'b1; ifc.push_data = 8'(8'h50 + c);
            tick();
        end
        ifc.push_valid = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("t5_level_before", int'(level), 4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t5_level_after", int'(level), 0);
        check("t5_pop_valid_after", int'(ifc.pop_valid), 0);
        check("t5_push_ready_after", int'(ifc.push_ready), 1);
        tick();
        ifc.push_valid = 1'b1; ifc.push_data = 8'h3C;
        tick();
        ifc.push_valid = 1'b0; ifc.pop_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && n == 0; c++) begin
            @(negedge clock);
            if (ifc.pop_valid) begin
                check("t5_first_pop", int'(ifc.pop_data), 8'h3C);
                n = 1;
            end
            tick();
        end
        check("t5_pop_seen", n, 1);
        repeat (2) tick();

        // 6: idle with pop_ready held
        ifc.pop_ready = 1'b1; ifc.push_valid = 1'b0;
        @(negedge clock);
        a0 = 8'(mem_address_out);
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("t6_raddr_const", int'(mem_address_out), int'(a0));
            check("t6_pop_valid", int'(ifc.pop_valid), 0);
            check("t6_level", int'(level), 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
